// File: rtl/csr_pkg.sv
// csr_pkg
//   Shared definitions for the CSR sequencing stage: request op encodings,
//   machine-mode CSR addresses, mstatus bit positions, sequencer state
//   encoding, and the two mstatus rewrite helpers used on trap entry and
//   on MRET.
package csr_pkg;

  // Request opcodes as presented on req_op.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_RW    = 3'd1,
    OP_RS    = 3'd2,
    OP_RC    = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_e;

  // Machine-mode CSR addresses touched by the trap sequences.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mstatus field positions.
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CSR_WR     = 3'd1,
    ST_TR_MEPC    = 3'd2,
    ST_TR_MCAUSE  = 3'd3,
    ST_TR_MSTATUS = 3'd4,
    ST_TR_JUMP    = 3'd5,
    ST_MR_STATUS  = 3'd6,
    ST_MR_JUMP    = 3'd7
  } state_e;

  // Trap entry: stash the interrupt enable in MPIE, mask interrupts and
  // record M-mode as the previous privilege.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE. The core is M-only, so
  // MPP stays at M rather than dropping to U.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_rmw.sv
// csr_rmw
//   Combinational read-modify-write for Zicsr instructions.
//   Ports:
//     op        in  3   request opcode (only RW/RS/RC produce a write)
//     old_val   in  32  current CSR value (already zeroed if unimplemented)
//     operand   in  32  rs1 value or zero-extended uimm
//     addr_ok   in  1   target address is implemented
//     new_val   out 32  value to write back
//     write_en  out 1   write is required
module csr_rmw
  import csr_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] old_val,
  input  logic [31:0] operand,
  input  logic        addr_ok,
  output logic [31:0] new_val,
  output logic        write_en
);

  always_comb begin
    new_val  = old_val;
    write_en = 1'b0;
    case (csr_op_e'(op))
      OP_RW: begin
        new_val  = operand;
        write_en = addr_ok;
      end
      // Set/clear with a zero mask is a pure read: no write side effects.
      OP_RS: begin
        new_val  = old_val | operand;
        write_en = addr_ok && (operand != 32'd0);
      end
      OP_RC: begin
        new_val  = old_val & ~operand;
        write_en = addr_ok && (operand != 32'd0);
      end
      default: begin
        new_val  = old_val;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Sequencer between the execute stage and the CSR register file. Turns
//   CSRRW/CSRRS/CSRRC, ECALL and MRET requests into ordered read/write
//   cycles on the file's single combinational read port and single write
//   port, returns the old CSR value for rd, and issues PC redirects.
//
//   Handshake: req_valid/req_op form a valid; !busy is the ready. A request
//   is taken in a cycle where the sequencer is idle, req_valid is high and
//   req_op is a defined non-NONE op. Upstream holds the request while busy;
//   requests seen while busy are ignored.
//
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     req_valid/op/csr_addr/operand/pc   execute-stage request
//     busy               stall while a sequence runs
//     rd_valid, rd_data  one-cycle pulse with the old CSR value
//     redirect_valid/pc  one-cycle pulse with the new fetch PC
//     csr_addr_r, csr_rdata                CSR file read port
//     csr_we, csr_addr_w, csr_wdata        CSR file write port
//     dbg_state          current sequencer state
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] CAUSE_ECALL = 32'd11,
  parameter logic [11:0] CSR_LO      = 12'h300,
  parameter logic [11:0] CSR_HI      = 12'h350
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_operand,
  input  logic [31:0] req_pc,
  output logic        busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [11:0] csr_addr_r,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [11:0] csr_addr_w,
  output logic [31:0] csr_wdata,
  output logic [2:0]  dbg_state
);

  state_e      state_q, state_d;
  csr_op_e     op;
  logic        is_csr_op;
  logic        is_defined_op;
  logic        addr_ok;
  logic        accept;
  logic [31:0] acc_old;
  logic [31:0] rmw_new;
  logic        rmw_we;

  // Request latches. old_q holds the old CSR value for Zicsr ops and the
  // sampled mstatus for trap/return sequences. jump_q holds mtvec or mepc.
  logic [11:0] addr_q;
  logic [31:0] pc_q;
  logic [31:0] old_q;
  logic [31:0] new_q;
  logic        we_q;
  logic [31:0] jump_q;

  assign op            = csr_op_e'(req_op);
  assign is_csr_op     = (op == OP_RW) || (op == OP_RS) || (op == OP_RC);
  assign is_defined_op = is_csr_op || (op == OP_ECALL) || (op == OP_MRET);
  assign addr_ok       = (req_csr_addr >= CSR_LO) && (req_csr_addr <= CSR_HI);
  assign accept        = (state_q == ST_IDLE) && req_valid && is_defined_op && !rst;

  // Unimplemented CSRs read as zero and never get written.
  assign acc_old = addr_ok ? csr_rdata : 32'd0;

  csr_rmw u_rmw (
    .op       (req_op),
    .old_val  (acc_old),
    .operand  (req_operand),
    .addr_ok  (addr_ok),
    .new_val  (rmw_new),
    .write_en (rmw_we)
  );

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  // Next state and port outputs.
  always_comb begin
    state_d        = state_q;
    rd_valid       = 1'b0;
    rd_data        = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    csr_addr_r     = CSR_MSTATUS;
    csr_we         = 1'b0;
    csr_addr_w     = 12'd0;
    csr_wdata      = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_csr_op) begin
            csr_addr_r = req_csr_addr;
            state_d    = ST_CSR_WR;
          end else if (op == OP_ECALL) begin
            state_d = ST_TR_MEPC;
          end else begin
            state_d = ST_MR_STATUS;
          end
        end
      end

      ST_CSR_WR: begin
        rd_valid = 1'b1;
        rd_data  = old_q;
        if (we_q) begin
          csr_we     = 1'b1;
          csr_addr_w = addr_q;
          csr_wdata  = new_q;
        end
        state_d = ST_IDLE;
      end

      ST_TR_MEPC: begin
        csr_we     = 1'b1;
        csr_addr_w = CSR_MEPC;
        csr_wdata  = {pc_q[31:2], 2'b00};
        state_d    = ST_TR_MCAUSE;
      end

      ST_TR_MCAUSE: begin
        csr_we     = 1'b1;
        csr_addr_w = CSR_MCAUSE;
        csr_wdata  = CAUSE_ECALL;
        state_d    = ST_TR_MSTATUS;
      end

      // The write port and read port are independent, so mtvec is fetched
      // in the same cycle that mstatus is rewritten.
      ST_TR_MSTATUS: begin
        csr_we     = 1'b1;
        csr_addr_w = CSR_MSTATUS;
        csr_wdata  = trap_mstatus(old_q);
        csr_addr_r = CSR_MTVEC;
        state_d    = ST_TR_JUMP;
      end

      // Exceptions always go to BASE, even in vectored mode.
      ST_TR_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = {jump_q[31:2], 2'b00};
        state_d        = ST_IDLE;
      end

      ST_MR_STATUS: begin
        csr_we     = 1'b1;
        csr_addr_w = CSR_MSTATUS;
        csr_wdata  = mret_mstatus(old_q);
        csr_addr_r = CSR_MEPC;
        state_d    = ST_MR_JUMP;
      end

      ST_MR_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = {jump_q[31:2], 2'b00};
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A reset cycle issues nothing: writes in flight are dropped and no
    // redirect leaves the block.
    if (rst) begin
      rd_valid       = 1'b0;
      rd_data        = 32'd0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      csr_addr_r     = CSR_MSTATUS;
      csr_we         = 1'b0;
      csr_addr_w     = 12'd0;
      csr_wdata      = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 12'd0;
      pc_q    <= 32'd0;
      old_q   <= 32'd0;
      new_q   <= 32'd0;
      we_q    <= 1'b0;
      jump_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_csr_addr;
        pc_q   <= req_pc;
        // Trap ops read mstatus on the default read address this cycle.
        old_q  <= is_csr_op ? acc_old : csr_rdata;
        new_q  <= rmw_new;
        we_q   <= rmw_we;
      end
      if ((state_q == ST_TR_MSTATUS) || (state_q == ST_MR_STATUS)) begin
        jump_q <= csr_rdata;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;
  import csr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid;
  logic [2:0]  req_op;
  logic [11:0] req_csr_addr;
  logic [31:0] req_operand;
  logic [31:0] req_pc;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_addr_r;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_addr_w;
  logic [31:0] csr_wdata;
  logic [2:0]  dbg_state;

  csr_trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_csr_addr   (req_csr_addr),
    .req_operand    (req_operand),
    .req_pc         (req_pc),
    .busy           (busy),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_addr_r     (csr_addr_r),
    .csr_rdata      (csr_rdata),
    .csr_we         (csr_we),
    .csr_addr_w     (csr_addr_w),
    .csr_wdata      (csr_wdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- CSR file (environment) ----------------
  logic [31:0] csr_file [0:4095];
  assign csr_rdata = csr_file[csr_addr_r];
  always @(posedge clk) if (csr_we) csr_file[csr_addr_w] <= csr_wdata;

  // ---------------- model state ----------------
  logic [31:0] model_csr [0:4095];

  typedef struct packed {
    logic        busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        we;
    logic [11:0] addr_w;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] redir_pc;
    logic [11:0] addr_r;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;
  logic [31:0] last_rd;
  logic [31:0] last_redir;
  int busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t idle_rec();
    exp_t r;
    r = '0;
    r.addr_r = 12'h300;
    return r;
  endfunction

  // ---------------- scoreboard compare ----------------
  exp_t cur;
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) cur = exp_t'(exp_q.pop_front());
      else cur = idle_rec();
      chk("busy", {31'd0, busy}, {31'd0, cur.busy});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, cur.rd_valid});
      if (cur.rd_valid) chk("rd_data", rd_data, cur.rd_data);
      chk("csr_we", {31'd0, csr_we}, {31'd0, cur.we});
      if (cur.we) begin
        chk("csr_addr_w", {20'd0, csr_addr_w}, {20'd0, cur.addr_w});
        chk("csr_wdata", csr_wdata, cur.wdata);
      end
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, cur.redir});
      if (cur.redir) chk("redirect_pc", redirect_pc, cur.redir_pc);
      chk("csr_addr_r", {20'd0, csr_addr_r}, {20'd0, cur.addr_r});
      if (rd_valid) last_rd = rd_data;
      if (redirect_valid) last_redir = redirect_pc;
      if (busy) busy_cnt++;
    end
  end

  // ---------------- model: expected cycles per request ----------------
  function automatic logic in_range(input logic [11:0] a);
    return (a >= 12'h300) && (a <= 12'h350);
  endfunction

  task automatic model_csr_op(input logic [2:0] op, input logic [11:0] addr,
                              input logic [31:0] operand);
    exp_t r;
    logic [31:0] old_v, new_v;
    logic wr;
    old_v = in_range(addr) ? model_csr[addr] : 32'd0;
    if (op == 3'd1) new_v = operand;
    else if (op == 3'd2) new_v = old_v | operand;
    else new_v = old_v & ~operand;
    wr = in_range(addr) && (op == 3'd1 || operand != 32'd0);
    r = idle_rec(); r.addr_r = addr; exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.rd_valid = 1'b1; r.rd_data = old_v;
    r.we = wr; r.addr_w = addr; r.wdata = new_v; exp_q.push_back(r);
    if (wr) model_csr[addr] = new_v;
  endtask

  task automatic model_ecall(input logic [31:0] pc);
    exp_t r;
    logic [31:0] ms, nms;
    ms  = model_csr[12'h300];
    nms = (ms & ~32'h0000_1888) | ({31'd0, ms[3]} << 7) | 32'h0000_1800;
    r = idle_rec(); exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.we = 1'b1; r.addr_w = 12'h341; r.wdata = pc & ~32'd3;
    exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.we = 1'b1; r.addr_w = 12'h342; r.wdata = 32'd11;
    exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.we = 1'b1; r.addr_w = 12'h300; r.wdata = nms;
    r.addr_r = 12'h305; exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.redir = 1'b1; r.redir_pc = model_csr[12'h305] & ~32'd3;
    exp_q.push_back(r);
    model_csr[12'h341] = pc & ~32'd3;
    model_csr[12'h342] = 32'd11;
    model_csr[12'h300] = nms;
  endtask

  task automatic model_mret();
    exp_t r;
    logic [31:0] ms, nms;
    ms  = model_csr[12'h300];
    nms = (ms & ~32'h0000_1888) | ({31'd0, ms[7]} << 3) | 32'h0000_1880;
    r = idle_rec(); exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.we = 1'b1; r.addr_w = 12'h300; r.wdata = nms;
    r.addr_r = 12'h341; exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.redir = 1'b1; r.redir_pc = model_csr[12'h341] & ~32'd3;
    exp_q.push_back(r);
    model_csr[12'h300] = nms;
  endtask

  // ---------------- driver ----------------
  // Called at #1 after a rising edge; returns at #1 after the edge that
  // brings the sequencer back to idle, so calls can run back to back.
  task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] operand, input logic [31:0] pc);
    int nbusy;
    if (op == 3'd4) begin model_ecall(pc); nbusy = 4; end
    else if (op == 3'd5) begin model_mret(); nbusy = 2; end
    else begin model_csr_op(op, addr, operand); nbusy = 1; end
    req_valid = 1'b1; req_op = op; req_csr_addr = addr;
    req_operand = operand; req_pc = pc;
    repeat (nbusy + 1) @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exp_t r;
    for (int i = 0; i < 4096; i++) begin
      csr_file[i] <= 32'd0;
      model_csr[i] = 32'd0;
    end
    csr_file[12'h340] <= 32'h1234_5678; model_csr[12'h340] = 32'h1234_5678;
    csr_file[12'h300] <= 32'h0000_1800; model_csr[12'h300] = 32'h0000_1800;
    csr_file[12'h305] <= 32'h0000_0170; model_csr[12'h305] = 32'h0000_0170;
    csr_file[12'h7C0] <= 32'hCAFE_F00D; model_csr[12'h7C0] = 32'hCAFE_F00D;
    last_rd = 32'd0; last_redir = 32'd0; busy_cnt = 0;

    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_csr_addr = 12'd0;
    req_operand = 32'd0; req_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset csr_we", {31'd0, csr_we}, 32'd0);
    chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset csr_addr_r", {20'd0, csr_addr_r}, 32'h300);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // CSRRW to an implemented address.
    issue(3'd1, 12'h340, 32'hDEAD_BEEF, 32'd0);
    chk("rw old literal", last_rd, 32'h1234_5678);
    chk("rw file literal", csr_file[12'h340], 32'hDEAD_BEEF);

    // CSRRS with zero mask is a pure read, then CSRRC back to back.
    issue(3'd2, 12'h300, 32'd0, 32'd0);
    chk("rs0 old literal", last_rd, 32'h0000_1800);
    issue(3'd3, 12'h300, 32'h0000_1000, 32'd0);
    chk("rc file literal", csr_file[12'h300], 32'h0000_0800);

    // Ignored: valid with NONE, and op without valid.
    req_valid = 1'b1; req_op = 3'd0; req_csr_addr = 12'h340;
    idle(2);
    req_valid = 1'b0; req_op = 3'd1;
    idle(2);
    req_op = 3'd0;

    // ECALL with mstatus = 0x1808.
    issue(3'd1, 12'h300, 32'h0000_1808, 32'd0);
    busy_cnt = 0;
    issue(3'd4, 12'h000, 32'd0, 32'h0000_0104);
    chk("ecall busy cycles", busy_cnt, 32'd4);
    chk("ecall mepc literal", csr_file[12'h341], 32'h0000_0104);
    chk("ecall mcause literal", csr_file[12'h342], 32'd11);
    chk("ecall mstatus literal", csr_file[12'h300], 32'h0000_1880);
    chk("ecall redirect literal", last_redir, 32'h0000_0170);

    // MRET with mepc = 0x106.
    issue(3'd1, 12'h341, 32'h0000_0106, 32'd0);
    busy_cnt = 0;
    issue(3'd5, 12'h000, 32'd0, 32'd0);
    chk("mret busy cycles", busy_cnt, 32'd2);
    chk("mret mstatus literal", csr_file[12'h300], 32'h0000_1888);
    chk("mret redirect literal", last_redir, 32'h0000_0104);

    // Unimplemented address reads zero and is not written.
    last_rd = 32'hFFFF_FFFF;
    issue(3'd1, 12'h7C0, 32'h5555_AAAA, 32'd0);
    chk("unimpl rd literal", last_rd, 32'd0);
    chk("unimpl file literal", csr_file[12'h7C0], 32'hCAFE_F00D);

    // Boundary addresses, set with nonzero mask, write-after-read.
    issue(3'd2, 12'h304, 32'h0000_0008, 32'd0);
    issue(3'd1, 12'h350, 32'h0000_00A5, 32'd0);
    issue(3'd1, 12'h351, 32'h0000_005A, 32'd0);
    issue(3'd1, 12'h340, 32'h0000_0001, 32'd0);
    issue(3'd2, 12'h340, 32'h0000_0002, 32'd0);
    chk("war rd literal", last_rd, 32'h0000_0001);
    chk("war file literal", csr_file[12'h340], 32'h0000_0003);
    for (int k = 0; k < 3; k++)
      issue(3'd3, 12'h340, 32'($urandom_range(0, 3)), 32'd0);

    // Reset while the ECALL sequence is writing mcause.
    issue(3'd1, 12'h342, 32'd0, 32'd0);
    r = idle_rec(); exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; r.we = 1'b1; r.addr_w = 12'h341;
    r.wdata = 32'h0000_0200; exp_q.push_back(r);
    r = idle_rec(); r.busy = 1'b1; exp_q.push_back(r);
    model_csr[12'h341] = 32'h0000_0200;
    last_redir = 32'd0;
    req_valid = 1'b1; req_op = 3'd4; req_pc = 32'h0000_0203;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    chk("abort mepc literal", csr_file[12'h341], 32'h0000_0200);
    chk("abort mcause literal", csr_file[12'h342], 32'd0);
    chk("abort mstatus literal", csr_file[12'h300], 32'h0000_1888);
    chk("abort no redirect", last_redir, 32'd0);

    chk_en = 1'b0;
    chk("exp queue drained", exp_q.size(), 32'd0);
    for (int a = 12'h300; a <= 12'h351; a++)
      chk($sformatf("file[%h]", a), csr_file[a], model_csr[a]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
